// File: rtl/cap_pkg.sv
// Shared types and constants for the capture sequencer.
// Frame geometry defaults match the 160x120 camera window.
package cap_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } cap_state_e;

  localparam int unsigned FRAME_W_DEF = 160;
  localparam int unsigned FRAME_H_DEF = 120;
  localparam int unsigned FRAME_PIX   = FRAME_W_DEF * FRAME_H_DEF;

  function automatic int unsigned frame_pix(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser plus stability debouncer.
// Emits a one-cycle pulse when an accepted level goes 0->1.
module btn_debounce #(
  parameter int DEB_CYC = 50000
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam logic [19:0] LAST = 20'(DEB_CYC - 1);

  logic        s1_q;
  logic        s2_q;
  logic        lvl_q;
  logic        lvl_d;
  logic        rise_q;
  logic        rise_d;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    cnt_d  = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      // sample differed from the held level DEB_CYC times running
      lvl_d  = s2_q;
      rise_d = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= btn_in;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: gates pixel writes into the frame buffer
// per vsync-delimited frame, with continuous or snapshot modes.
module capture_ctrl
  import cap_pkg::*;
#(
  parameter int AW      = 15,
  parameter int FRAME_W = 160,
  parameter int FRAME_H = 120,
  parameter int DEB_CYC = 50000
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic          btn_snap,
  input  logic          mode_cont,
  input  logic          in_wr,
  input  logic [AW-1:0] in_addr,
  input  logic [7:0]    in_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          frame_err
);

  localparam logic [AW:0] FPIX_C =
    (AW+1)'(frame_pix(FRAME_W, FRAME_H));
  localparam logic [7:0] FH_C = 8'(FRAME_H);

  cap_state_e    state_q, state_d;
  logic          vsync_q;
  logic          href_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          pxwr_q, pxwr_d;
  logic          fdone_q, fdone_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          ferr_q, ferr_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [7:0]    ln_cnt_q, ln_cnt_d;

  logic          vs_fall;
  logic          vs_rise;
  logic          href_rise;
  logic          in_cap;
  logic          in_rng;
  logic          accept;
  logic          oob;
  logic [AW:0]   wr_nxt;
  logic [7:0]    ln_nxt;
  logic          snap_req;
  logic          btn_lvl;

  btn_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_deb (
    .pclk  (pclk),
    .rst   (rst),
    .btn_in(btn_snap),
    .level (btn_lvl),
    .rise  (snap_req)
  );

  assign vs_fall   = !vsync & vsync_q;
  assign vs_rise   = vsync & !vsync_q;
  assign href_rise = href & !href_q;

  assign in_cap = (state_q == CAPT);
  assign in_rng = ({1'b0, in_addr} < FPIX_C);
  assign accept = in_cap & in_wr & in_rng;
  assign oob    = in_cap & in_wr & !in_rng;

  // counters saturate so an overlong frame cannot alias to a good one
  assign wr_nxt = (accept && wr_cnt_q != '1) ?
                  wr_cnt_q + 1'b1 : wr_cnt_q;
  assign ln_nxt = (in_cap && href_rise && ln_cnt_q != '1) ?
                  ln_cnt_q + 8'd1 : ln_cnt_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pxwr_d   = 1'b0;
    fdone_d  = 1'b0;
    fcnt_d   = fcnt_q;
    ferr_d   = ferr_q;
    wr_cnt_d = wr_cnt_q;
    ln_cnt_d = ln_cnt_q;

    if (accept) begin
      pxwr_d = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end

    unique case (state_q)
      ARM: begin
        if (vs_fall) begin
          state_d  = CAPT;
          wr_cnt_d = '0;
          ln_cnt_d = '0;
        end
      end
      CAPT: begin
        wr_cnt_d = wr_nxt;
        ln_cnt_d = ln_nxt;
        if (oob) begin
          ferr_d = 1'b1;
        end
        if (vs_rise) begin
          fdone_d = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          if (wr_nxt != FPIX_C || ln_nxt != FH_C) begin
            ferr_d = 1'b1;
          end
          state_d = mode_cont ? ARM : HOLD;
        end
      end
      HOLD: begin
        if (snap_req || mode_cont) begin
          state_d = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= ARM;
      vsync_q  <= 1'b1;
      href_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pxwr_q   <= 1'b0;
      fdone_q  <= 1'b0;
      fcnt_q   <= '0;
      ferr_q   <= 1'b0;
      wr_cnt_q <= '0;
      ln_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync;
      href_q   <= href;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pxwr_q   <= pxwr_d;
      fdone_q  <= fdone_d;
      fcnt_q   <= fcnt_d;
      ferr_q   <= ferr_d;
      wr_cnt_q <= wr_cnt_d;
      ln_cnt_q <= ln_cnt_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = pxwr_q;
  assign busy        = in_cap;
  assign frame_done  = fdone_q;
  assign frame_cnt   = fcnt_q;
  assign frame_err   = ferr_q;

  logic unused_ok;
  assign unused_ok = btn_lvl;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl on a scaled 8x4 frame.
// Debounce window shortened to keep the run brief.
module tb_capture_ctrl;

  localparam int AW  = 15;
  localparam int FW  = 8;
  localparam int FH  = 4;
  localparam int DEB = 16;
  localparam int FP  = FW * FH;

  logic          pclk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          href;
  logic          btn_snap;
  logic          mode_cont;
  logic          in_wr;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int px_cnt = 0;
  int fd_cnt = 0;

  capture_ctrl #(
    .AW(AW), .FRAME_W(FW), .FRAME_H(FH), .DEB_CYC(DEB)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .btn_snap   (btn_snap),
    .mode_cont  (mode_cont),
    .in_wr      (in_wr),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .mem_px_addr(mem_px_addr),
    .mem_px_data(mem_px_data),
    .px_wr      (px_wr),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .frame_err  (frame_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (px_wr === 1'b1) px_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return v;
  endfunction

  // one vsync-low window; expw says whether writes should pass
  task automatic frame(input string tag, input int lines,
                       input bit expw, input bit oob,
                       input bit rise_wr);
    int p0;
    int bad;
    int a;
    p0  = px_cnt;
    bad = 0;
    vsync   = 1'b0;
    in_wr   = 1'b1;
    in_addr = 15'd5;
    in_data = 8'h11;
    tick(1);
    in_wr = 1'b0;
    tick(1);
    chk({tag, "_vsfall_drop"}, 32'(px_wr), 32'd0);
    if (oob) begin
      in_wr   = 1'b1;
      in_addr = 15'(FP);
      tick(1);
      chk({tag, "_oob_lo"}, 32'(px_wr), 32'd0);
      in_addr = 15'h7fff;
      tick(1);
      chk({tag, "_oob_hi"}, 32'(px_wr), 32'd0);
      in_wr = 1'b0;
    end
    for (int l = 0; l < lines; l++) begin
      href = 1'b1;
      for (int p = 0; p < FW; p++) begin
        a       = l * FW + p;
        in_wr   = 1'b1;
        in_addr = 15'(a);
        in_data = pix(a);
        if (rise_wr && l == lines - 1 && p == FW - 1)
          vsync = 1'b1;
        tick(1);
        if (px_wr !== expw) bad++;
        if (expw && (mem_px_addr !== 15'(a) ||
                     mem_px_data !== pix(a))) bad++;
      end
      in_wr = 1'b0;
      href  = 1'b0;
      tick(1);
    end
    vsync = 1'b1;
    tick(2);
    chk({tag, "_latency"}, 32'(bad), 32'd0);
    chk({tag, "_px_count"}, 32'(px_cnt - p0),
        expw ? 32'(lines * FW) : 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int fd0;
    rst       = 1'b1;
    vsync     = 1'b1;
    href      = 1'b0;
    btn_snap  = 1'b0;
    mode_cont = 1'b1;
    in_wr     = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_addr", 32'(mem_px_addr), 32'd0);
    chk("rst_data", 32'(mem_px_data), 32'd0);
    chk("rst_pxwr", 32'(px_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    tick(2);

    // continuous, two frames; second ends with write on vs_rise
    fd0 = fd_cnt;
    frame("cont1", FH, 1'b1, 1'b0, 1'b0);
    frame("cont2", FH, 1'b1, 1'b0, 1'b1);
    chk("cont_done", 32'(fd_cnt - fd0), 32'd2);
    chk("cont_cnt", 32'(frame_cnt), 32'd2);
    chk("cont_err", 32'(frame_err), 32'd0);

    // snapshot: third frame captured, fourth frozen
    mode_cont = 1'b0;
    frame("snap1", FH, 1'b1, 1'b0, 1'b0);
    chk("snap1_cnt", 32'(frame_cnt), 32'd3);
    fd0 = fd_cnt;
    frame("hold1", FH, 1'b0, 1'b0, 1'b0);
    chk("hold1_done", 32'(fd_cnt - fd0), 32'd0);
    chk("hold1_cnt", 32'(frame_cnt), 32'd3);

    // bouncing button never stable for DEB cycles
    for (int i = 0; i < 10; i++) begin
      btn_snap = ~btn_snap;
      tick(8);
    end
    btn_snap = 1'b0;
    tick(40);
    frame("bounce", FH, 1'b0, 1'b0, 1'b0);
    chk("bounce_cnt", 32'(frame_cnt), 32'd3);

    // clean press releases HOLD
    btn_snap = 1'b1;
    tick(DEB + 10);
    btn_snap = 1'b0;
    tick(30);
    frame("snap2", FH, 1'b1, 1'b0, 1'b0);
    chk("snap2_cnt", 32'(frame_cnt), 32'd4);
    chk("snap2_err", 32'(frame_err), 32'd0);

    // out-of-range writes flag a sticky error
    mode_cont = 1'b1;
    tick(2);
    frame("oob", FH, 1'b1, 1'b1, 1'b0);
    chk("oob_err", 32'(frame_err), 32'd1);
    chk("oob_cnt", 32'(frame_cnt), 32'd5);
    frame("clean", FH, 1'b1, 1'b0, 1'b0);
    chk("sticky_err", 32'(frame_err), 32'd1);
    chk("clean_cnt", 32'(frame_cnt), 32'd6);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_err", 32'(frame_err), 32'd0);
    chk("rst2_cnt", 32'(frame_cnt), 32'd0);

    // short frame: one line and its writes missing
    fd0 = fd_cnt;
    frame("short", FH - 1, 1'b1, 1'b0, 1'b0);
    chk("short_done", 32'(fd_cnt - fd0), 32'd1);
    chk("short_cnt", 32'(frame_cnt), 32'd1);
    chk("short_err", 32'(frame_err), 32'd1);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // reset in the middle of a capture
    vsync = 1'b0;
    tick(1);
    href = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_wr   = 1'b1;
      in_addr = 15'(i);
      in_data = pix(i);
      tick(1);
    end
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_pxwr", 32'(px_wr), 32'd1);
    rst   = 1'b1;
    in_wr = 1'b0;
    href  = 1'b0;
    vsync = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_addr", 32'(mem_px_addr), 32'd0);
    chk("mid_data", 32'(mem_px_data), 32'd0);
    chk("mid_pxwr0", 32'(px_wr), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_done0", 32'(frame_done), 32'd0);
    chk("mid_cnt0", 32'(frame_cnt), 32'd0);
    chk("mid_err0", 32'(frame_err), 32'd0);
    tick(2);
    frame("after", FH, 1'b1, 1'b0, 1'b0);
    chk("after_cnt", 32'(frame_cnt), 32'd1);
    chk("after_err", 32'(frame_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
